// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and op-class helpers. Optional feature macro: MDU_MADD_EN.
package mdu_iter_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_CALC = 2'd1,
    MDU_S_FIX  = 2'd2,
    MDU_S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

  // Ops that run through CALC/FIX; accumulate ops only exist with MDU_MADD_EN.
  function automatic logic mdu_is_calc(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op <= MDU_DIVU) || (op >= MDU_MADD);
`else
    return (op <= MDU_DIVU);
`endif
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // Partial remainder is one bit wider than the operands; the kept remainder
  // is always below the divisor, so it fits back into WIDTH bits.
  logic [WIDTH:0] partial;

  assign partial = {rem_i, bit_i};
  assign q_o     = (partial >= {1'b0, divisor_i});
  assign rem_o   = q_o ? WIDTH'(partial - {1'b0, divisor_i}) : partial[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MSUB accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  logic               sgn_op, s0, s1;
  logic [WIDTH-1:0]   abs0, abs1;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_sum;
`endif

  assign sgn_op = mdu_is_signed(op_i);
  assign s0     = sgn_op & src0_i[WIDTH-1];
  assign s1     = sgn_op & src1_i[WIDTH-1];
  assign abs0   = s0 ? -src0_i : src0_i;
  assign abs1   = s1 ? -src1_i : src1_i;

  // Shift-add: upper half accumulates the multiplicand when the LSB is set.
  assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (prod_q[WIDTH-1]),
    .divisor_i (mcand_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
`ifdef MDU_MADD_EN
  assign acc_sum  = (op_q == MDU_MSUB) ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      MDU_S_IDLE: begin
        if (start_i && !flush_i) begin
          if (op_i == MDU_MTHI) begin
            hi_d = src0_i;
          end else if (op_i == MDU_MTLO) begin
            lo_d = src0_i;
          end else if (mdu_is_calc(op_i)) begin
            op_d      = op_i;
            cnt_d     = '0;
            rem_d     = '0;
            neg_res_d = s0 ^ s1;
            neg_rem_d = s0;
            dbz_d     = mdu_is_div(op_i) && (src1_i == '0);
            // Low half holds the dividend (divide) or the multiplier (multiply).
            if (mdu_is_div(op_i)) begin
              prod_d  = {{WIDTH{1'b0}}, abs0};
              mcand_d = abs1;
            end else begin
              prod_d  = {{WIDTH{1'b0}}, abs1};
              mcand_d = abs0;
            end
            state_d = MDU_S_CALC;
          end
        end
      end
      MDU_S_CALC: begin
        if (flush_i) begin
          state_d = MDU_S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (mdu_is_div(op_q)) begin
            rem_d  = step_rem;
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], step_q};
          end else begin
            prod_d = {add_sum, prod_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MDU_S_FIX;
        end
      end
      MDU_S_FIX: begin
        if (flush_i) begin
          state_d = MDU_S_IDLE;
        end else begin
          // With a zero divisor the remainder is the dividend magnitude, so
          // the dividend-sign fix-up reproduces src0 exactly.
          if (mdu_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = dbz_q ? '1 : quo_fix;
`ifdef MDU_MADD_EN
          end else if ((op_q == MDU_MADD) || (op_q == MDU_MSUB)) begin
            {hi_d, lo_d} = acc_sum;
`endif
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = MDU_S_DONE;
        end
      end
      MDU_S_DONE: begin
        state_d = MDU_S_IDLE;
      end
      default: begin
        state_d = MDU_S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= MDU_S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o = (state_q == MDU_S_CALC) || (state_q == MDU_S_FIX);
  assign done_o = (state_q == MDU_S_DONE) && !flush_i;
  assign dbz_o  = done_o && dbz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
